fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from execute and the
// {instruction, pc} handoff toward decode.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a credit limit
// and buffers returned words with their PCs in a small FIFO toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_e;

  state_e        state_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifoCount_q, fifoCount_d;
  logic [PW-1:0] fifoRd_q, fifoWr_q, tagRd_q, tagWr_q;
  logic [31:0]   fifoInstr_q [DEPTH];
  logic [31:0]   fifoPc_q [DEPTH];
  logic [31:0]   tag_q [DEPTH];
  logic [CW+1:0] inFlight;
  logic          redirect, reqFire, rspDrop, rspPush, popFire;
  logic [1:0]    unusedRedirectLsbs;

  assign redirect           = bus.redirect_valid;
  assign unusedRedirectLsbs = bus.redirect_pc[1:0];

  // Every slot that could still become a FIFO entry holds a credit, so the FIFO cannot overflow.
  assign inFlight = (CW+2)'(outstanding_q) + (CW+2)'(drop_q) + (CW+2)'(fifoCount_q);

  assign bus.imem_req_valid = (state_q == RUN) && !redirect && (inFlight < (CW+2)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = (fifoCount_q != '0);
  assign bus.id_instruction = fifoInstr_q[fifoRd_q];
  assign bus.id_pc          = fifoPc_q[fifoRd_q];

  assign reqFire = bus.imem_req_valid && bus.imem_req_ready;
  assign rspDrop = bus.imem_rsp_valid && (drop_q != '0);
  assign rspPush = bus.imem_rsp_valid && (drop_q == '0);
  assign popFire = bus.id_valid && bus.id_ready;

  always_comb begin
    pc_d          = reqFire ? pc_q + 32'd4 : pc_q;
    outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspPush);
    drop_d        = drop_q - CW'(rspDrop);
    fifoCount_d   = fifoCount_q + CW'(rspPush) - CW'(popFire);
    // A response arriving with the redirect belongs to the wrong path as well.
    if (redirect) begin
      pc_d          = {bus.redirect_pc[31:2], 2'b00};
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - CW'(bus.imem_rsp_valid);
      fifoCount_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifoCount_q   <= '0;
      fifoRd_q      <= '0;
      fifoWr_q      <= '0;
      tagRd_q       <= '0;
      tagWr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifoInstr_q[i] <= NOP;
        fifoPc_q[i]    <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      state_q       <= RUN;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifoCount_q   <= fifoCount_d;
      if (redirect) begin
        fifoRd_q <= '0;
        fifoWr_q <= '0;
        tagRd_q  <= '0;
        tagWr_q  <= '0;
      end else begin
        if (reqFire) begin
          tag_q[tagWr_q] <= pc_q;
          tagWr_q        <= tagWr_q + PW'(1);
        end
        if (rspPush) begin
          fifoInstr_q[fifoWr_q] <= bus.imem_rsp_data;
          fifoPc_q[fifoWr_q]    <= tag_q[tagRd_q];
          fifoWr_q              <= fifoWr_q + PW'(1);
          tagRd_q               <= tagRd_q + PW'(1);
        end
        if (popFire) begin
          fifoRd_q <= fifoRd_q + PW'(1);
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (!redirect && rspPush && !popFire) |-> (fifoCount_q < CW'(DEPTH)));
endmodule
